// File: rtl/shift_pkg.sv
// shift_pkg: mode encodings, burst FSM states and a width-generic next-value function
package shift_pkg;
    localparam logic [2:0] MODE_HOLD = 3'd0;
    localparam logic [2:0] MODE_SHL  = 3'd1;
    localparam logic [2:0] MODE_SHR  = 3'd2;
    localparam logic [2:0] MODE_LOAD = 3'd3;
    localparam logic [2:0] MODE_ROTL = 3'd4;
    localparam logic [2:0] MODE_ROTR = 3'd5;
    localparam logic [2:0] MODE_ASHR = 3'd6;
    localparam logic [2:0] MODE_RSVD = 3'd7;
    localparam int MAXW = 64;

    typedef enum logic {ST_IDLE, ST_RUN} state_e;

    // Operates on the low w bits of a MAXW-wide vector; load and reserved hold.
    function automatic logic [MAXW-1:0] next_val(input logic [MAXW-1:0] v, input logic [2:0] op,
                                                 input logic sl, input logic sr, input int w);
        logic [MAXW-1:0] m, t, x;
        logic hi;
        m = (w >= MAXW) ? '1 : (MAXW'(1) << w) - MAXW'(1);
        t = MAXW'(1) << (w - 1);
        x = v & m;
        hi = |(x & t);
        case (op)
            MODE_SHL:  return ((x << 1) | MAXW'(sr)) & m;
            MODE_SHR:  return (x >> 1) | (sl ? t : '0);
            MODE_ROTL: return ((x << 1) | MAXW'(hi)) & m;
            MODE_ROTR: return (x >> 1) | (x[0] ? t : '0);
            MODE_ASHR: return (x >> 1) | (hi ? t : '0);
            default:   return x;
        endcase
    endfunction
endpackage

// File: rtl/usr_step.sv
// usr_step: combinational one-step next value of the shift register
module usr_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic [2:0]       op_i,
    input  logic             sin_l_i,
    input  logic             sin_r_i,
    output logic [WIDTH-1:0] next_q_o
);
    assign next_q_o = WIDTH'(next_val(MAXW'(q_i), op_i, sin_l_i, sin_r_i, WIDTH));
endmodule

// File: rtl/univ_shift_reg_p.sv
// univ_shift_reg_p: universal shift register with parallel load and an N-shift burst engine
module univ_shift_reg_p
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld,
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic             start,
    input  logic [CW-1:0]    nshift,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);
    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [2:0]       bmode_q;
    logic [WIDTH-1:0] q_q, q_d, step_q;
    logic             done_q;
    logic [2:0]       op;

    // While a burst runs the latched mode replaces the live one.
    assign op = (state_q == ST_RUN) ? bmode_q : mode;

    usr_step #(.WIDTH(WIDTH)) u_step (
        .q_i      (q_q),
        .op_i     (op),
        .sin_l_i  (sin_l),
        .sin_r_i  (sin_r),
        .next_q_o (step_q)
    );

    assign q_d = (mode == MODE_LOAD) ? din : step_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bmode_q <= MODE_HOLD;
            q_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (ld) begin
                q_q     <= din;
                state_q <= ST_IDLE;
                cnt_q   <= '0;
            end else if (state_q == ST_RUN) begin
                if (en) begin
                    q_q   <= step_q;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                end
            end else if (start) begin
                if (nshift != '0) begin
                    state_q <= ST_RUN;
                    cnt_q   <= nshift;
                    bmode_q <= mode;
                end else begin
                    done_q <= 1'b1;
                end
            end else if (en) begin
                q_q <= q_d;
            end
        end
    end

    assign q      = q_q;
    assign sout_l = q_q[WIDTH-1];
    assign sout_r = q_q[0];
    assign busy   = (state_q == ST_RUN);
    assign done   = done_q;
endmodule

// File: tb/tb_univ_shift_reg_p.sv
// tb_univ_shift_reg_p: directed and random checks of 8- and 5-bit instances against an arithmetic model
module tb_univ_shift_reg_p;
    logic       clk = 1'b0;
    logic       reset, ld, en, sin_r, sin_l, start;
    logic [7:0] din;
    logic [2:0] mode;
    logic [3:0] nshift;
    logic [7:0] q8;
    logic [4:0] q5;
    logic       sl8, sr8, busy8, done8, sl5, sr5, busy5, done5;
    int         n_pass = 0, n_tot = 0;
    int         mq[2], mrem[2], mdone[2], wid[2];
    logic [2:0] mbm[2];

    always #5 clk = ~clk;

    univ_shift_reg_p #(.WIDTH(8)) u8 (
        .clk(clk), .reset(reset), .ld(ld), .din(din), .en(en), .mode(mode),
        .sin_r(sin_r), .sin_l(sin_l), .start(start), .nshift(nshift),
        .q(q8), .sout_l(sl8), .sout_r(sr8), .busy(busy8), .done(done8)
    );

    univ_shift_reg_p #(.WIDTH(5)) u5 (
        .clk(clk), .reset(reset), .ld(ld), .din(din[4:0]), .en(en), .mode(mode),
        .sin_r(sin_r), .sin_l(sin_l), .start(start), .nshift(nshift[2:0]),
        .q(q5), .sout_l(sl5), .sout_r(sr5), .busy(busy5), .done(done5)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) $display("FAIL %s got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic int apply(input int v, input int w, input logic [2:0] m, input logic sl, input logic sr);
        int full, half;
        full = 1 << w;
        half = full / 2;
        case (m)
            3'd1: return (v * 2 + int'(sr)) % full;
            3'd2: return v / 2 + (sl ? half : 0);
            3'd4: return (v * 2) % full + v / half;
            3'd5: return v / 2 + (v % 2) * half;
            3'd6: return v / 2 + (v >= half ? half : 0);
            default: return v;
        endcase
    endfunction

    task automatic model_edge();
        int ns, d;
        for (int i = 0; i < 2; i++) begin
            ns = int'(nshift) % (1 << (i ? 3 : 4));
            d = int'(din) % (1 << wid[i]);
            mdone[i] = 0;
            if (reset) begin
                mq[i] = 0;
                mrem[i] = 0;
            end else if (ld) begin
                mq[i] = d;
                mrem[i] = 0;
            end else if (mrem[i] > 0) begin
                if (en) begin
                    mq[i] = apply(mq[i], wid[i], mbm[i], sin_l, sin_r);
                    mrem[i]--;
                    if (mrem[i] == 0) mdone[i] = 1;
                end
            end else if (start) begin
                if (ns != 0) begin
                    mrem[i] = ns;
                    mbm[i] = mode;
                end else mdone[i] = 1;
            end else if (en) begin
                mq[i] = (mode == 3'd3) ? d : apply(mq[i], wid[i], mode, sin_l, sin_r);
            end
        end
    endtask

    task automatic cyc(input logic r, input logic l, input logic [7:0] d, input logic e, input logic [2:0] m,
                       input logic sr, input logic sl, input logic st, input logic [3:0] ns);
        reset = r; ld = l; din = d; en = e; mode = m; sin_r = sr; sin_l = sl; start = st; nshift = ns;
        @(posedge clk);
        model_edge();
        #1;
        chk("q8", q8, mq[0]);
        chk("busy8", busy8, mrem[0] > 0);
        chk("done8", done8, mdone[0]);
        chk("soutl8", sl8, (mq[0] >> 7) & 1);
        chk("soutr8", sr8, mq[0] & 1);
        chk("q5", q5, mq[1]);
        chk("busy5", busy5, mrem[1] > 0);
        chk("done5", done5, mdone[1]);
        chk("soutl5", sl5, (mq[1] >> 4) & 1);
        chk("soutr5", sr5, mq[1] & 1);
    endtask

    initial begin
        int nb;
        logic [4:0] pat;
        wid[0] = 8; wid[1] = 5;
        for (int i = 0; i < 2; i++) begin
            mq[i] = 0; mrem[i] = 0; mdone[i] = 0; mbm[i] = 3'd0;
        end
        cyc(1, 0, 8'h00, 0, 3'd0, 0, 0, 0, 4'd0);
        chk("rst_q", q8, 0);
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        cyc(0, 1, 8'hA5, 0, 3'd0, 0, 0, 0, 4'd0);
        chk("ld_a5", q8, 8'hA5);
        cyc(0, 0, 8'h00, 1, 3'd1, 1, 0, 0, 4'd0);
        chk("shl", q8, 8'h4B);
        chk("shl_soutl", sl8, 0);
        cyc(0, 1, 8'h81, 0, 3'd0, 0, 0, 0, 4'd0);
        cyc(0, 0, 8'h00, 1, 3'd5, 0, 0, 0, 4'd0);
        chk("rotr", q8, 8'hC0);
        cyc(0, 0, 8'h00, 1, 3'd6, 0, 0, 0, 4'd0);
        chk("ashr", q8, 8'hE0);
        cyc(0, 0, 8'h00, 1, 3'd2, 0, 0, 0, 4'd0);
        chk("shr", q8, 8'h70);
        // burst rotl x3, then the same with a two-cycle stall
        for (int k = 0; k < 2; k++) begin
            pat = (k == 0) ? 5'b00111 : 5'b11001;
            cyc(0, 1, 8'h01, 0, 3'd0, 0, 0, 0, 4'd0);
            cyc(0, 0, 8'h00, 1, 3'd4, 0, 0, 1, 4'd3);
            chk("burst_q_hold", q8, 8'h01);
            nb = int'(busy8);
            for (int j = 0; j < (k ? 5 : 3); j++) begin
                cyc(0, 0, 8'h00, pat[j], 3'd0, 0, 0, 0, 4'd0);
                nb += int'(busy8);
            end
            chk("burst_busy_len", nb, k ? 5 : 3);
            chk("burst_q", q8, 8'h08);
            chk("burst_done", done8, 1);
            cyc(0, 0, 8'h00, 0, 3'd0, 0, 0, 0, 4'd0);
            chk("burst_done_low", done8, 0);
        end
        cyc(0, 0, 8'h00, 0, 3'd4, 0, 0, 1, 4'd0);
        chk("ns0_done", done8, 1);
        chk("ns0_busy", busy8, 0);
        chk("ns0_q", q8, 8'h08);
        cyc(0, 1, 8'h01, 0, 3'd0, 0, 0, 0, 4'd0);
        cyc(0, 0, 8'h00, 1, 3'd4, 0, 0, 1, 4'd5);
        cyc(0, 0, 8'h00, 1, 3'd1, 1, 0, 1, 4'd7);
        chk("start_busy_ign", q8, 8'h02);
        cyc(0, 0, 8'h00, 1, 3'd0, 0, 0, 0, 4'd0);
        cyc(0, 1, 8'h3C, 1, 3'd0, 0, 0, 1, 4'd3);
        chk("abort_q", q8, 8'h3C);
        chk("abort_busy", busy8, 0);
        chk("abort_done", done8, 0);
        cyc(0, 0, 8'h00, 1, 3'd4, 0, 0, 1, 4'd4);
        cyc(0, 0, 8'h00, 1, 3'd0, 0, 0, 0, 4'd0);
        cyc(1, 0, 8'h00, 1, 3'd0, 0, 0, 0, 4'd0);
        chk("midrst_q", q8, 0);
        chk("midrst_busy", busy8, 0);
        chk("midrst_done", done8, 0);
        cyc(0, 1, 8'h01, 0, 3'd0, 0, 0, 0, 4'd0);
        cyc(0, 0, 8'h00, 1, 3'd4, 0, 0, 1, 4'd7);
        repeat (7) cyc(0, 0, 8'h00, 1, 3'd0, 0, 0, 0, 4'd0);
        chk("w5_rotl7", q5, 5'h04);
        chk("w8_rotl7", q8, 8'h80);
        chk("w5_done", done5, 1);
        repeat (600)
            cyc($urandom_range(63) == 0, $urandom_range(15) == 0, 8'($urandom), $urandom_range(3) != 0,
                3'($urandom), 1'($urandom), 1'($urandom), $urandom_range(5) == 0, 4'($urandom));
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
